// File: rtl/wb_trace_recorder.sv
// wb_trace_recorder
//
// Purpose:
//   Records the CPU write-back debug stream as 72-bit trace records in the
//   layout the trace checker consumes:
//     {pc[31:0], 3'b000, addr[4:0], wdata[31:0]}
//   Records are buffered in a small show-ahead FIFO and drained over a
//   valid/ready stream. Recording stops when END_PC reaches write-back.
//   After that, the FIFO drains and `done` rises once it is empty.
//
// Parameters:
//   DEPTH   - FIFO entries (power of two, >= 2)
//   END_PC  - write-back PC that ends recording
//
// Ports:
//   clk                - single clock, rising edge
//   reset              - synchronous, active-high, clears all state
//   debug_wb_pc        - PC of the instruction in write-back
//   debug_wb_rf_wen    - register-file write enable in write-back
//   debug_wb_rf_addr   - destination register number
//   debug_wb_rf_wdata  - write-back data
//   rec_valid          - rec_data holds a record (FIFO not empty)
//   rec_ready          - consumer accepts the record this cycle
//   rec_data           - head FIFO record
//   rec_count          - records accepted into the FIFO, saturating
//   overflow           - sticky, an event was dropped on a full FIFO
//   done               - end PC seen and FIFO drained, held until reset
//
// Configuration macro:
//   WB_TRACE_ZERO_FILTER_EN - when defined, writes to register $0 are not
//                             recorded (the checker skips $0).

module wb_trace_recorder #(
  parameter int          DEPTH  = 8,
  parameter logic [31:0] END_PC = 32'h0000006c
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] debug_wb_pc,
  input  logic        debug_wb_rf_wen,
  input  logic [4:0]  debug_wb_rf_addr,
  input  logic [31:0] debug_wb_rf_wdata,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [71:0] rec_data,
  output logic [31:0] rec_count,
  output logic        overflow,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [71:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic empty;
  logic full;
  logic is_end;
  logic addr_ok;
  logic capture;
  logic pop;
  logic push;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // indices with differing wrap bits mean full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

`ifdef WB_TRACE_ZERO_FILTER_EN
  assign addr_ok = (debug_wb_rf_addr != 5'd0);
`else
  assign addr_ok = 1'b1;
`endif

  // The end-PC cycle is never recorded, even when it writes a register.
  assign is_end  = (debug_wb_pc == END_PC);
  assign capture = (state == RUN) && debug_wb_rf_wen && !is_end && addr_ok;

  assign rec_valid = !empty;
  assign rec_data  = mem[rd_ptr[AW-1:0]];
  assign pop       = rec_valid && rec_ready;
  // At full, a same-cycle pop frees the slot being written.
  assign push      = capture && (!full || pop);

  // Storage has no reset; only entries between the pointers are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {debug_wb_pc, 3'b000, debug_wb_rf_addr,
                              debug_wb_rf_wdata};
    end
  end

  // FIFO pointers, accepted-record counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rec_count <= 32'd0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (rec_count != 32'hffffffff) begin
          rec_count <= rec_count + 32'd1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (capture && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Recording control. DRAIN waits for the consumer to empty the FIFO so that
  // done never rises while a record is still outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      done  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (is_end) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          state <= RUN;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_trace_recorder.sv
// tb_wb_trace_recorder
//
// Purpose:
//   Directed testbench for wb_trace_recorder (DEPTH=8, END_PC=0x6c).
//   Stimulus pushes the expected records into a scoreboard queue. A monitor
//   process pops the queue and compares each record the DUT hands over.
//   The stimulus process also checks count, flag and state outputs directly.
//
// Ports: none (top-level bench).

module tb_wb_trace_recorder;

  logic        clk;
  logic        reset;
  logic [31:0] debug_wb_pc;
  logic        debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_addr;
  logic [31:0] debug_wb_rf_wdata;
  logic        rec_valid;
  logic        rec_ready;
  logic [71:0] rec_data;
  logic [31:0] rec_count;
  logic        overflow;
  logic        done;

  int n_compared;
  int n_mismatched;

  logic [71:0] sb [$];

  // Record count contributed by the $0 write, which depends on the build.
`ifdef WB_TRACE_ZERO_FILTER_EN
  localparam bit ZERO_RECORDED = 1'b0;
`else
  localparam bit ZERO_RECORDED = 1'b1;
`endif

  wb_trace_recorder #(
    .DEPTH (8),
    .END_PC(32'h0000006c)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .debug_wb_pc      (debug_wb_pc),
    .debug_wb_rf_wen  (debug_wb_rf_wen),
    .debug_wb_rf_addr (debug_wb_rf_addr),
    .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .rec_valid        (rec_valid),
    .rec_ready        (rec_ready),
    .rec_data         (rec_data),
    .rec_count        (rec_count),
    .overflow         (overflow),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and step the shared counters.
  task automatic check_output(input string name, input logic [71:0] actual,
                              input logic [71:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one write-back cycle (called just after a rising edge). If the
  // event is expected to enter the FIFO, its record goes into the
  // scoreboard.
  task automatic apply_stimulus(input logic [31:0] pc, input logic wen,
                                input logic [4:0] addr,
                                input logic [31:0] wdata, input bit exp);
    debug_wb_pc       = pc;
    debug_wb_rf_wen   = wen;
    debug_wb_rf_addr  = addr;
    debug_wb_rf_wdata = wdata;
    if (exp) sb.push_back({pc, 3'b000, addr, wdata});
    @(posedge clk);
    #1;
    debug_wb_rf_wen = 1'b0;
    debug_wb_pc     = 32'h0;
  endtask

  task automatic idle(input int n);
    debug_wb_rf_wen = 1'b0;
    debug_wb_pc     = 32'h0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: inputs only change just after a rising edge, so a handshake seen
  // on the falling edge is the one the next rising edge will complete.
  always @(negedge clk) begin
    if (!reset && rec_valid && rec_ready) begin
      if (sb.size() == 0) begin
        check_output("unexpected_record", rec_data, 72'h0);
      end else begin
        check_output("record", rec_data, sb.pop_front());
      end
    end
  end

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    n_compared        = 0;
    n_mismatched      = 0;
    reset             = 1'b1;
    rec_ready         = 1'b0;
    debug_wb_pc       = 32'h0;
    debug_wb_rf_wen   = 1'b0;
    debug_wb_rf_addr  = 5'd0;
    debug_wb_rf_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check_output("reset_valid", {71'd0, rec_valid}, 72'd0);
    check_output("reset_count", {40'd0, rec_count}, 72'd0);
    check_output("reset_overflow", {71'd0, overflow}, 72'd0);
    check_output("reset_done", {71'd0, done}, 72'd0);

    // Single write with the consumer ready.
    rec_ready = 1'b1;
    apply_stimulus(32'h4, 1'b1, 5'd5, 32'hdeadbeef, 1'b1);
    check_output("single_valid", {71'd0, rec_valid}, 72'd1);
    check_output("single_data", rec_data, 72'h00000004_05_deadbeef);
    check_output("single_count", {40'd0, rec_count}, 72'd1);
    idle(1);

    // Fill the FIFO, then write while popping at full.
    rec_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(32'h100 + 32'(i * 4), 1'b1, 5'(i + 1),
                     32'ha000 + 32'(i), 1'b1);
    end
    check_output("fill_count", {40'd0, rec_count}, 72'd9);
    check_output("fill_overflow", {71'd0, overflow}, 72'd0);
    rec_ready = 1'b1;
    apply_stimulus(32'h120, 1'b1, 5'd9, 32'ha008, 1'b1);
    check_output("fullpop_overflow", {71'd0, overflow}, 72'd0);
    check_output("fullpop_count", {40'd0, rec_count}, 72'd10);
    idle(9);
    check_output("fullpop_drained", {71'd0, rec_valid}, 72'd0);

    // Backpressure: nine writes into an eight-entry FIFO, the ninth dropped.
    rec_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(32'h200 + 32'(i * 4), 1'b1, 5'(i + 10),
                     32'hb000 + 32'(i), (i < 8));
    end
    check_output("bp_count", {40'd0, rec_count}, 72'd18);
    check_output("bp_overflow", {71'd0, overflow}, 72'd1);
    rec_ready = 1'b1;
    idle(10);
    check_output("bp_drained", {71'd0, rec_valid}, 72'd0);
    check_output("bp_overflow_sticky", {71'd0, overflow}, 72'd1);

    // Reset mid-run with three records buffered.
    rec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(32'h300 + 32'(i * 4), 1'b1, 5'(i + 20),
                     32'hc000 + 32'(i), 1'b0);
    end
    check_output("pre_reset_count", {40'd0, rec_count}, 72'd21);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    sb.delete();
    check_output("midreset_valid", {71'd0, rec_valid}, 72'd0);
    check_output("midreset_count", {40'd0, rec_count}, 72'd0);
    check_output("midreset_overflow", {71'd0, overflow}, 72'd0);
    check_output("midreset_done", {71'd0, done}, 72'd0);
    rec_ready = 1'b1;
    apply_stimulus(32'h40, 1'b1, 5'd2, 32'h12345678, 1'b1);
    check_output("post_reset_count", {40'd0, rec_count}, 72'd1);
    idle(1);

    // Write to $0: recorded only when the zero filter is off.
    apply_stimulus(32'h44, 1'b1, 5'd0, 32'hcafef00d, ZERO_RECORDED);
    check_output("zero_count", {40'd0, rec_count},
                 ZERO_RECORDED ? 72'd2 : 72'd1);
    idle(1);

    // End PC: 0x68 is recorded, 0x6c is not, later writes are ignored.
    rec_ready = 1'b0;
    apply_stimulus(32'h68, 1'b1, 5'd7, 32'h11111111, 1'b1);
    apply_stimulus(32'h6c, 1'b1, 5'd3, 32'h22222222, 1'b0);
    idle(2);
    check_output("end_done_held", {71'd0, done}, 72'd0);
    check_output("end_count", {40'd0, rec_count},
                 ZERO_RECORDED ? 72'd3 : 72'd2);
    rec_ready = 1'b1;
    idle(1);
    check_output("end_popped_valid", {71'd0, rec_valid}, 72'd0);
    check_output("end_done_not_yet", {71'd0, done}, 72'd0);
    idle(1);
    check_output("end_done", {71'd0, done}, 72'd1);
    apply_stimulus(32'h70, 1'b1, 5'd9, 32'h33333333, 1'b0);
    idle(2);
    check_output("after_done_valid", {71'd0, rec_valid}, 72'd0);
    check_output("after_done_count", {40'd0, rec_count},
                 ZERO_RECORDED ? 72'd3 : 72'd2);
    check_output("after_done_done", {71'd0, done}, 72'd1);
    check_output("scoreboard_empty", 72'(sb.size()), 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
